// File: rtl/ram_burst_master.sv
// Burst initiator for a 512x8 single-port RAM: one command becomes a run of
// single-cycle RAM accesses, with write data in and read data out on valid/ready.
`timescale 1ns/1ps
module ram_burst_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WRITE | one RAM write per accepted wr beat
  // READ  | fetch into rd_data while the output slot is free or draining
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam int CW = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     cnt;
  logic              fetch;

  assign cmd_ready   = (state == IDLE);
  assign wr_ready    = (state == WRITE);
  assign ram_load    = (state == WRITE) && wr_valid;
  assign ram_address = addr;
  assign ram_in      = wr_data;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign fetch       = (state == READ) && (cnt != '0) && (!rd_valid || rd_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_addr;
            cnt   <= CW'(cmd_len) + CW'(1);
            state <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr <= addr + ADDR_W'(1);
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        READ: begin
          if (fetch) begin
            rd_data  <= ram_out;
            rd_valid <= 1'b1;
            addr     <= addr + ADDR_W'(1);
            cnt      <= cnt - CW'(1);
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
            // with nothing left to fetch, the last word leaving ends the burst
            if (cnt == '0 && rd_valid) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, reference memory
// image, and queue-based scoreboards for RAM writes and read-stream words.
`timescale 1ns/1ps
module tb_ram_burst_master;
  localparam int DW = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic [DW-1:0] ram_in, ram_out;
  logic          ram_load;
  logic [AW-1:0] ram_address;

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  // RAM array the master drives: combinational read, write on rising edge
  logic [DW-1:0] mem [512];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  logic [DW-1:0]      ref_mem [512];
  logic [DW-1:0]      rq[$];
  logic [AW+DW-1:0]   wq[$];
  logic [DW-1:0]      wdq[$];
  int                 n_chk = 0, n_fail = 0, done_cnt = 0;
  logic               hold_pend = 1'b0;
  logic [DW-1:0]      hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a RAM write or a read word
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("rd_hold_valid", 32'(rd_valid), 32'd1);
        check("rd_hold_data", 32'(rd_data), 32'(hold_data));
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) timeout("rd_word_unexpected");
        else check("rd_data", 32'(rd_data), 32'(rq.pop_front()));
      end
      hold_pend = rd_valid && !rd_ready;
      hold_data = rd_data;
      if (ram_load) begin
        if (wq.size() == 0) timeout("ram_load_unexpected");
        else begin
          logic [AW+DW-1:0] e;
          e = wq.pop_front();
          check("ram_write_addr", 32'(ram_address), 32'(e[AW+DW-1:DW]));
          check("ram_write_data", 32'(ram_in), 32'(e[DW-1:0]));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input bit w, input int a, input int l);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(a); cmd_len = AW'(l);
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("cmd_accept");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int a, input int l, input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i <= l; i++) begin
      int g, t;
      logic [AW-1:0] ad;
      logic [DW-1:0] d;
      g  = (i == gap_at) ? gap_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      ad = AW'(a + i);
      d  = wdq.pop_front();
      wr_valid = 1'b0;
      repeat (g) begin
        @(negedge clk);
        check("gap_no_load", 32'(ram_load), 32'd0);
        check("gap_addr_frozen", 32'(ram_address), 32'(ad));
        tick();
      end
      wq.push_back({ad, d});
      ref_mem[ad] = d;
      wr_valid = 1'b1; wr_data = d;
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) timeout("wr_ready_wait");
      check("busy_cmd_held_off", 32'(cmd_ready), 32'd0);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Entered at the negedge where done is expected high
  task automatic finish_burst(input int dc0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_cmd_ready", 32'(cmd_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("after_done_low", 32'(done), 32'd0);
    check("after_done_cmd_ready", 32'(cmd_ready), 32'd1);
    check("after_done_idle", 32'(busy), 32'd0);
    check("done_once", 32'(done_cnt), 32'(dc0 + 1));
    tick();
  endtask

  task automatic push_read(input int a, input int l);
    for (int i = 0; i <= l; i++) rq.push_back(ref_mem[AW'(a + i)]);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic run_read(input int l, input int mode, input int dc0);
    int n, bound;
    n = 0;
    bound = 8 * (l + 1) + 100;
    while (1) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      n++;
      if (done) break;
      if (n >= bound) begin timeout("read_done_wait"); break; end
      tick();
    end
    if (mode == 0) check("read_throughput_cycles", 32'(n), 32'(l + 3));
    check("read_words_all_seen", 32'(rq.size()), 32'd0);
    finish_burst(dc0);
    rd_ready = 1'b0;
  endtask

  task automatic do_write(input int a, input int l, input int gap_at, input int gap_len, input bit rnd);
    int dc0;
    dc0 = done_cnt;
    cmd(1'b1, a, l);
    write_beats(a, l, gap_at, gap_len, rnd);
    @(negedge clk);
    finish_burst(dc0);
  endtask

  task automatic do_read(input int a, input int l, input int mode);
    int dc0;
    dc0 = done_cnt;
    push_read(a, l);
    cmd(1'b0, a, l);
    run_read(l, mode, dc0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ram_load", 32'(ram_load), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // whole-array fill 0..255,0..255 then full-speed readback
    for (int i = 0; i < 512; i++) wdq.push_back(DW'(i));
    do_write(0, 511, -1, 0, 1'b0);
    do_read(0, 511, 0);

    // three back-to-back bytes
    wdq = '{8'hA1, 8'hB2, 8'hC3};
    do_write('h010, 2, -1, 0, 1'b0);
    do_read('h010, 2, 0);

    // wrap at the top of the array
    wdq = '{8'h5A, 8'hC7, 8'h3E};
    do_write('h1FE, 2, -1, 0, 1'b0);
    do_read('h1FE, 2, 0);

    // stalled reader across the wrap
    do_read('h1FE, 3, 1);

    // command held off during a burst, with a 5-cycle write gap
    dc0 = done_cnt;
    wdq = '{8'h91, 8'h92, 8'h93, 8'h94};
    cmd(1'b1, 'h080, 3);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'('h080); cmd_len = AW'(3);
    write_beats('h080, 3, 2, 5, 1'b0);
    @(negedge clk);
    finish_burst(dc0);
    cmd_valid = 1'b0;
    dc0 = done_cnt;
    push_read('h080, 3);
    run_read(3, 0, dc0);

    // reset in the middle of a 4-word write
    wdq = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd(1'b1, 'h040, 3);
    write_beats('h040, 1, -1, 0, 1'b0);
    wdq.delete();
    wr_valid = 1'b1; wr_data = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ram_load", 32'(ram_load), 32'd0);
    check("midrst_wr_ready", 32'(wr_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_ram_address", 32'(ram_address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    do_read('h040, 3, 0);

    // randomized write/readback bursts
    for (int k = 0; k < 6; k++) begin
      int a, l;
      a = int'($urandom_range(0, 511));
      l = int'($urandom_range(0, 40));
      for (int i = 0; i <= l; i++) wdq.push_back(DW'($urandom));
      do_write(a, l, -1, 0, 1'b1);
      do_read(a, l, 2);
      do_read(int'($urandom_range(0, 511)), int'($urandom_range(0, 20)), 2);
    end

    check("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
